alu_cmd_issue: RTL

ALU_CMD_ISSUE -- requirements
Module: alu_cmd_issue

---
 rtl/alu_cmd_issue.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/alu_cmd_issue.sv
// Command issue stage: buffers ALU commands in a FIFO, feeds one at a time to an
// external combinational arithmetic unit, and holds each result until the consumer accepts it.
module alu_cmd_issue #(
  parameter int unsigned N     = 4,
  parameter int unsigned M     = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [N-1:0]             cmd_a,
  input  logic [N-1:0]             cmd_b,
  input  logic [M-2:0]             cmd_op,
  output logic [N-1:0]             au_a,
  output logic [N-1:0]             au_b,
  output logic [M-2:0]             au_instr,
  input  logic [N-1:0]             au_result,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [N-1:0]             res_data,
  output logic [M-2:0]             res_op,
  output logic                     res_err,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int unsigned OW = M - 1;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [OW-1:0] OP_DIV = OW'(3);

  typedef struct packed {
    logic [OW-1:0] op;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_e;

  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] cnt_q, cnt_d;
  state_e        state_q, state_d;
  cmd_t          opr_q, opr_d;
  logic          res_valid_q, res_valid_d;
  logic [N-1:0]  res_data_q, res_data_d;
  logic [OW-1:0] res_op_q, res_op_d;
  logic          res_err_q, res_err_d;
  logic          push, pop, fifo_empty;

  // Ready depends only on the registered level, never on a same-cycle pop.
  assign cmd_ready  = (cnt_q != LW'(DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign push       = cmd_valid && cmd_ready;

  always_comb begin
    state_d     = state_q;
    opr_d       = opr_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_op_d    = res_op_q;
    res_err_d   = res_err_q;
    pop         = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        res_valid_d = 1'b1;
        res_op_d    = opr_q.op;
        state_d     = HOLD;
        // Divide by zero overrides whatever the arithmetic unit returns.
        if (opr_q.op == OP_DIV && opr_q.b == '0) begin
          res_data_d = '1;
          res_err_d  = 1'b1;
        end else begin
          res_data_d = au_result;
          res_err_d  = 1'b0;
        end
      end
      HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) opr_d = mem_q[rd_ptr_q];

    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    cnt_d    = cnt_q + LW'(push) - LW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{op: cmd_op, a: cmd_a, b: cmd_b};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      opr_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_op_q    <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      opr_q       <= opr_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_op_q    <= res_op_d;
      res_err_q   <= res_err_d;
    end
  end

  assign au_a       = opr_q.a;
  assign au_b       = opr_q.b;
  assign au_instr   = opr_q.op;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_op     = res_op_q;
  assign res_err    = res_err_q;
  assign fifo_level = cnt_q;

endmodule
